apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
// APB initiator: the requester end of the APB link whose completer is the SSI register slave.
// Accepts single read/write commands on a valid/ready command port and runs APB SETUP and ACCESS phases.
// Waits on p_ready and returns read data or an error on a valid/ready response port.
// Sits between a local controller (CPU/DMA shim) and the apb_ssi_top slave.
// PARAMETERS
// ADDR_WIDTH      32  width of cmd_addr/p_addr
// DATA_WIDTH      32  width of all data buses
// TIMEOUT_CYCLES  16  max ACCESS cycles waiting for p_ready; 0 = no timeout
// PORTS
// p_clk       in   1           clock, all state on rising edge
// p_reset     in   1           asynchronous, active-high reset
// cmd_valid   in   1           command request
// cmd_ready   out  1           command accepted when cmd_valid&&cmd_ready at edge
// cmd_write   in   1           1=write, 0=read
// cmd_addr    in   ADDR_WIDTH  byte address, must be word aligned
// cmd_wdata   in   DATA_WIDTH  write data
// rsp_valid   out  1           response available
// rsp_ready   in   1           response consumed when rsp_valid&&rsp_ready at edge
// rsp_rdata   out  DATA_WIDTH  read data (0 for writes and errors)
// rsp_err     out  1           1=timeout or misaligned address
// p_sel       out  1           APB select
// p_enable    out  1           APB enable
// p_write     out  1           APB direction
// p_addr      out  ADDR_WIDTH  APB address
// p_wdata     out  DATA_WIDTH  APB write data (0 during reads)
// p_rdata     in   DATA_WIDTH  APB read data, sampled only when p_ready=1 in ACCESS
// p_ready     in   1           APB completer ready
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE. Outputs p_sel, p_enable, p_write, p_addr, p_wdata, rsp_valid, rsp_rdata and rsp_err are 0.
// - cmd_ready is 0 while p_reset=1.
// - FSM states: IDLE, SETUP, ACCESS, RESP. cmd_ready=1 only in IDLE. Exactly one outstanding command.
// - IDLE: on handshake with cmd_addr[1:0]!=0, go to RESP with rsp_err=1 and rsp_rdata=0; no bus cycle.
// - IDLE: on handshake with an aligned address, register write/addr/wdata and go to SETUP.
// - SETUP (exactly 1 cycle): p_sel=1, p_enable=0, p_write/p_addr/p_wdata valid; next state is ACCESS.
// - ACCESS: p_sel=1, p_enable=1; address, data and control held stable.
// - ACCESS, p_ready=1: capture p_rdata (reads) or 0 (writes) into rsp_rdata, set rsp_err=0, go to RESP.
// - ACCESS, p_ready=0: increment the wait counter.
// - ACCESS timeout: if TIMEOUT_CYCLES!=0 and the ACCESS cycle count reaches TIMEOUT_CYCLES with p_ready=0, abort.
//   Abort sets rsp_err=1, rsp_rdata=0 and goes to RESP.
// - RESP: p_sel=0, p_enable=0, rsp_valid=1; outputs held until rsp_ready=1, then go to IDLE.
// - p_addr/p_write/p_wdata return to 0 in IDLE/RESP.
// - Latency: cmd accepted at edge k; SETUP in cycle k+1; ACCESS from k+2; zero-wait rsp_valid in cycle k+3.
//   Each wait state adds 1 cycle. Next cmd_ready=1 the cycle after the rsp handshake.
// - The wait counter clears on entry to SETUP; its width is clog2(TIMEOUT_CYCLES+1), and it never wraps.
// - A late p_ready in the same cycle the counter hits its limit counts as success (p_ready has priority).
// - Reset mid-transfer: p_sel/p_enable drop asynchronously and the in-flight command is dropped without a response.
// - cmd_* inputs are ignored outside IDLE. rsp_ready is ignored when rsp_valid=0.
// TESTING
// - Write addr 0x04 data 0xAB, p_ready tied 1 -> SETUP(sel=1,en=0), ACCESS(sel=1,en=1,addr=0x04,wdata=0xAB,write=1),
//   then rsp_valid=1, rsp_err=0, rsp_rdata=0.
// - Read addr 0x0C, p_ready low 3 ACCESS cycles then high with p_rdata=0x0000_1234
//   -> 5 cycles of p_sel=1, rsp_rdata=0x1234, rsp_err=0, p_wdata=0 throughout.
// - Read addr 0x08, p_ready stuck 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, p_sel=0.
// - Write addr 0x06 -> rsp_valid the cycle after accept with rsp_err=1; p_sel never asserts.
// - rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable and cmd_ready=0 for all 5 cycles.
// - p_reset pulsed during ACCESS -> p_sel/p_enable=0 in the same cycle; no rsp_valid; new command accepted after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: accepts one command at a time on a valid/ready port, runs the
// APB SETUP/ACCESS phases with an optional wait timeout and returns a response.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  p_clk_i,
    input  logic                  p_reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  p_sel_o,
    output logic                  p_enable_o,
    output logic                  p_write_o,
    output logic [ADDR_WIDTH-1:0] p_addr_o,
    output logic [DATA_WIDTH-1:0] p_wdata_o,
    input  logic [DATA_WIDTH-1:0] p_rdata_i,
    input  logic                  p_ready_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    p_sel_q, p_sel_d;
    logic                    p_enable_q, p_enable_d;
    logic                    p_write_q, p_write_d;
    logic [ADDR_WIDTH-1:0]   p_addr_q, p_addr_d;
    logic [DATA_WIDTH-1:0]   p_wdata_q, p_wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    timeout_hit;

    // Command port is open only when idle and out of reset.
    assign cmd_ready_o = (state_q == ST_IDLE) && !p_reset_i;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(LIMIT));

    always_ff @(posedge p_clk_i or posedge p_reset_i) begin
        if (p_reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p_sel_q     <= 1'b0;
            p_enable_q  <= 1'b0;
            p_write_q   <= 1'b0;
            p_addr_q    <= '0;
            p_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_sel_q     <= p_sel_d;
            p_enable_q  <= p_enable_d;
            p_write_q   <= p_write_d;
            p_addr_q    <= p_addr_d;
            p_wdata_q   <= p_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_sel_d     = p_sel_q;
        p_enable_d  = p_enable_q;
        p_write_d   = p_write_q;
        p_addr_d    = p_addr_q;
        p_wdata_d   = p_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_addr_i[1:0] != 2'b00) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = ST_SETUP;
                        cnt_d      = '0;
                        p_sel_d    = 1'b1;
                        p_enable_d = 1'b0;
                        p_write_d  = cmd_write_i;
                        p_addr_d   = cmd_addr_i;
                        p_wdata_d  = cmd_write_i ? cmd_wdata_i : '0;
                    end
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                p_enable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A ready on the limit cycle still completes the transfer.
                if (p_ready_i || timeout_hit) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !p_ready_i;
                    rsp_rdata_d = (p_ready_i && !p_write_q) ? p_rdata_i : '0;
                    p_sel_d     = 1'b0;
                    p_enable_d  = 1'b0;
                    p_write_d   = 1'b0;
                    p_addr_d    = '0;
                    p_wdata_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign p_sel_o     = p_sel_q;
    assign p_enable_o  = p_enable_q;
    assign p_write_o   = p_write_q;
    assign p_addr_o    = p_addr_q;
    assign p_wdata_o   = p_wdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed cases plus random transactions checked
// against a word-addressed completer memory and transaction-level timing rules.
module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          p_sel, p_enable, p_write, p_ready;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .p_clk_i(clk), .p_reset_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .p_sel_o(p_sel), .p_enable_o(p_enable), .p_write_o(p_write),
        .p_addr_o(p_addr), .p_wdata_o(p_wdata),
        .p_rdata_i(p_rdata), .p_ready_i(p_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // One command end to end; waits<0 means the completer never becomes ready.
    task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int waits, input int hold);
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [DW-1:0] rd_val;
        int            sel_seen;
        int            exp_sel;
        bit            done;
        exp_rd = '0; exp_err = 1'b0; sel_seen = 0; done = 0; rd_val = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        p_ready = 1'($urandom_range(0, 1)); rsp_ready = 1'($urandom_range(0, 1));
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~wr;
        cmd_addr = $urandom; cmd_wdata = $urandom;
        if (addr[1:0] != 2'b00) begin
            exp_err = 1'b1;
        end else begin
            chk("setup_sel", 64'(p_sel), 64'd1);
            chk("setup_en", 64'(p_enable), 64'd0);
            chk("setup_write", 64'(p_write), 64'(wr));
            chk("setup_addr", 64'(p_addr), 64'(addr));
            chk("setup_wdata", 64'(p_wdata), wr ? 64'(wd) : 64'd0);
            if (p_sel) sel_seen++;
            for (int i = 0; i < 64 && !done; i++) begin
                @(negedge clk);
                p_ready = (waits >= 0 && i >= waits);
                rd_val = mem_rd(addr);
                p_rdata = (p_ready && !wr) ? rd_val : DW'($urandom);
                rsp_ready = 1'($urandom_range(0, 1));
                if (p_sel) sel_seen++;
                chk("access_sel", 64'(p_sel), 64'd1);
                chk("access_en", 64'(p_enable), 64'd1);
                chk("access_addr", 64'(p_addr), 64'(addr));
                chk("access_wdata", 64'(p_wdata), wr ? 64'(wd) : 64'd0);
                chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
                if (p_ready) begin
                    done = 1;
                    exp_rd = wr ? '0 : rd_val;
                    if (wr) mem[addr] = wd;
                end else if (waits < 0 && i + 1 == int'(TO)) begin
                    done = 1;
                    exp_err = 1'b1;
                end
            end
            chk("access_bound", 64'(done), 64'd1);
            exp_sel = (waits < 0) ? 1 + int'(TO) : 2 + waits;
            chk("sel_cycles", 64'(sel_seen), 64'(exp_sel));
            @(negedge clk);
        end
        p_ready = 1'($urandom_range(0, 1));
        rsp_ready = (hold == 0);
        if (hold == 0) cmd_valid = 1'b0;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("rsp_p_sel", 64'(p_sel), 64'd0);
        chk("rsp_p_en", 64'(p_enable), 64'd0);
        chk("rsp_p_addr", 64'(p_addr), 64'd0);
        chk("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == hold - 1) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
            chk("hold_err", 64'(rsp_err), 64'(exp_err));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("after_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("after_p_sel", 64'(p_sel), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            w;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; p_ready = 1'b0; p_rdata = '0;
        mem[32'h0000_000C] = 32'h0000_1234;
        #1;
        chk("reset_p_sel", 64'(p_sel), 64'd0);
        chk("reset_p_en", 64'(p_enable), 64'd0);
        chk("reset_p_addr", 64'(p_addr), 64'd0);
        chk("reset_p_wdata", 64'(p_wdata), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        txn(1'b1, 32'h04, 32'hAB, 0, 0);
        txn(1'b0, 32'h0C, 32'h0, 3, 0);
        txn(1'b0, 32'h08, 32'h0, -1, 0);
        txn(1'b1, 32'h06, 32'h55, 0, 0);
        txn(1'b0, 32'h04, 32'h0, 1, 5);

        // Reset pulse in the middle of ACCESS drops the transfer.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; p_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_en", 64'(p_enable), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_p_sel", 64'(p_sel), 64'd0);
        chk("midrst_p_en", 64'(p_enable), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        chk("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1);

        for (int n = 0; n < 30; n++) begin
            ra = AW'({$urandom_range(0, 15), 2'b00});
            if ($urandom_range(0, 5) == 0) ra = ra | AW'($urandom_range(1, 3));
            w = $urandom_range(0, 9);
            if (w == 9) w = -1;
            else if (w > 4) w = 0;
            txn(1'($urandom_range(0, 1)), ra, DW'($urandom), w, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
